// File: rtl/layer_seq_pkg.sv
// Shared definitions for the layer sequencer: FSM state encoding and default sizing.
package layer_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_GO     = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FDONE  = 3'd4
    } seq_state_t;

    localparam int DEFAULT_NUM_LAYERS    = 3;
    localparam int DEFAULT_SETTLE_CYCLES = 2;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with zero flag; used for input settling and the layer watchdog.
module seq_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/layer_sequencer.sv
// Frame sequencer issuing go/done handshakes to a chain of layer engines, with one-deep request queue.
// Optional per-layer watchdog enabled by defining LAYER_WATCHDOG_EN.
module layer_sequencer
    import layer_seq_pkg::*;
#(
    parameter int NUM_LAYERS    = DEFAULT_NUM_LAYERS,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int WD_CYCLES     = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NUM_LAYERS-1:0] done,
    output logic [NUM_LAYERS-1:0] go,
    output logic [2:0]            layer_idx,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun,
    output logic                  wd_err
);

    localparam int SW = 4;

    if (NUM_LAYERS < 2 || NUM_LAYERS > 8 || SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15
        || WD_CYCLES < 2) begin : g_bad_param
        $error("layer_sequencer: parameter out of range");
    end

    seq_state_t state, state_n;
    logic                  pending, pending_n, overrun_n;
    logic [NUM_LAYERS-1:0] sel;
    logic                  done_hit, last_layer, wd_expire;
    logic                  settle_zero, settle_load;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            sel[i] = (layer_idx == 3'(i));
        end
    end

    // Only the done bit of the layer currently being waited on counts.
    assign done_hit   = (state == ST_WAIT) && |(done & sel);
    assign last_layer = (layer_idx == 3'(NUM_LAYERS - 1));

    assign settle_load = (state_n == ST_SETTLE) && (state != ST_SETTLE);

    seq_down_counter #(.W(SW)) u_settle (
        .clk      (clk),
        .reset    (reset),
        .load     (settle_load),
        .load_val (SW'(SETTLE_CYCLES - 1)),
        .dec      (state == ST_SETTLE),
        .zero     (settle_zero)
    );

`ifdef LAYER_WATCHDOG_EN
    localparam int WDW = $clog2(WD_CYCLES + 1);
    logic wd_zero;
    logic wd_err_q;

    // Loaded in the GO cycle so the first WAIT cycle sees the full limit.
    seq_down_counter #(.W(WDW)) u_wd (
        .clk      (clk),
        .reset    (reset),
        .load     (state == ST_GO),
        .load_val (WDW'(WD_CYCLES - 1)),
        .dec      (state == ST_WAIT),
        .zero     (wd_zero)
    );

    assign wd_expire = (state == ST_WAIT) && wd_zero && !done_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_err_q <= 1'b0;
        end else if (wd_expire) begin
            wd_err_q <= 1'b1;
        end
    end

    assign wd_err = wd_err_q;
`else
    assign wd_expire = 1'b0;
    assign wd_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (start || pending) state_n = ST_SETTLE;
            ST_SETTLE: if (settle_zero) state_n = ST_GO;
            ST_GO:     state_n = ST_WAIT;
            ST_WAIT: begin
                if (wd_expire) begin
                    state_n = ST_IDLE;
                end else if (done_hit) begin
                    state_n = last_layer ? ST_FDONE : ST_GO;
                end
            end
            ST_FDONE:  state_n = pending ? ST_SETTLE : ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != ST_IDLE);
        frame_done = (state == ST_FDONE);
        go         = (state == ST_GO) ? sel : '0;
    end

    // A queued request is consumed when the FSM leaves IDLE or FDONE on its behalf.
    always_comb begin
        pending_n = pending;
        overrun_n = overrun;
        if (pending && ((state == ST_IDLE) || (state == ST_FDONE))) begin
            pending_n = 1'b0;
        end
        if (start && busy) begin
            if (pending) begin
                overrun_n = 1'b1;
            end else begin
                pending_n = 1'b1;
            end
        end else if (start && pending && (state == ST_IDLE)) begin
            pending_n = 1'b1;
        end
        if (wd_expire) begin
            pending_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= 1'b0;
            overrun   <= 1'b0;
            layer_idx <= 3'd0;
        end else begin
            pending <= pending_n;
            overrun <= overrun_n;
            if (done_hit && !last_layer) begin
                layer_idx <= layer_idx + 3'd1;
            end else if ((state == ST_FDONE) || wd_expire) begin
                layer_idx <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: per-cycle vector table plus multi-cycle scenarios.
module tb_layer_sequencer;

    localparam int NL = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [NL-1:0] done = '0;
    logic [NL-1:0] go;
    logic [2:0]    layer_idx;
    logic          busy, frame_done, overrun, wd_err;

    always #5 clk = ~clk;

    layer_sequencer #(
        .NUM_LAYERS    (NL),
        .SETTLE_CYCLES (2),
        .WD_CYCLES     (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .done       (done),
        .go         (go),
        .layer_idx  (layer_idx),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun),
        .wd_err     (wd_err)
    );

    typedef struct {
        logic          s;
        logic [NL-1:0] d;
        logic [NL-1:0] g;
        logic          b;
        logic          f;
        int            idx;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc, rcnt, fd_cnt, first_fd, last_fd, last_go0, busy_drop;
    logic [NL-1:0] rmask = '0;
    logic [NL-1:0] resp_en = '0;
    vec_t tbl[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive inputs just after the edge, sample outputs on the falling edge.
    // Enabled layers answer their go with done exactly 5 cycles later.
    task automatic tick(input logic s, input logic r, input logic [NL-1:0] dx);
        @(posedge clk);
        #1;
        cyc++;
        start = s;
        reset = r;
        if (rcnt > 0) begin
            rcnt--;
            done = dx | ((rcnt == 0) ? (rmask & resp_en) : '0);
        end else begin
            done = dx;
        end
        @(negedge clk);
        if (|go) begin
            rmask = go;
            rcnt  = 5;
            if (go[0]) last_go0 = cyc;
        end
        if (frame_done) begin
            fd_cnt++;
            if (first_fd < 0) first_fd = cyc;
            last_fd = cyc;
        end
    endtask

    task automatic restart();
        tick(1'b0, 1'b1, '0);
        tick(1'b0, 1'b1, '0);
        tick(1'b0, 1'b0, '0);
        cyc = -1; rcnt = 0; fd_cnt = 0; first_fd = -1; last_fd = -1; last_go0 = -1;
    endtask

    function automatic vec_t v(input logic s, input logic [NL-1:0] d, input logic [NL-1:0] g,
                               input logic b, input logic f, input int idx);
        vec_t r;
        r.s = s; r.d = d; r.g = g; r.b = b; r.f = f; r.idx = idx;
        return r;
    endfunction

    initial begin
        // start, done, go, busy, frame_done, layer_idx (-1 = not checked)
        tbl[0]  = v(1, 3'b000, 3'b000, 0, 0, 0);
        tbl[1]  = v(0, 3'b000, 3'b000, 1, 0, 0);
        tbl[2]  = v(0, 3'b000, 3'b000, 1, 0, 0);
        tbl[3]  = v(0, 3'b001, 3'b001, 1, 0, 0);
        tbl[4]  = v(0, 3'b000, 3'b000, 1, 0, 0);
        tbl[5]  = v(0, 3'b100, 3'b000, 1, 0, 0);
        tbl[6]  = v(0, 3'b010, 3'b000, 1, 0, 0);
        tbl[7]  = v(0, 3'b000, 3'b000, 1, 0, 0);
        tbl[8]  = v(0, 3'b001, 3'b000, 1, 0, 0);
        tbl[9]  = v(0, 3'b000, 3'b010, 1, 0, 1);
        tbl[10] = v(0, 3'b001, 3'b000, 1, 0, 1);
        tbl[11] = v(0, 3'b000, 3'b000, 1, 0, 1);
        tbl[12] = v(0, 3'b000, 3'b000, 1, 0, 1);
        tbl[13] = v(0, 3'b100, 3'b000, 1, 0, 1);
        tbl[14] = v(0, 3'b010, 3'b000, 1, 0, 1);
        tbl[15] = v(0, 3'b000, 3'b100, 1, 0, 2);
        tbl[16] = v(0, 3'b000, 3'b000, 1, 0, 2);
        tbl[17] = v(0, 3'b011, 3'b000, 1, 0, 2);
        tbl[18] = v(0, 3'b000, 3'b000, 1, 0, 2);
        tbl[19] = v(0, 3'b000, 3'b000, 1, 0, 2);
        tbl[20] = v(0, 3'b100, 3'b000, 1, 0, 2);
        tbl[21] = v(0, 3'b000, 3'b000, 1, 1, -1);
        tbl[22] = v(0, 3'b000, 3'b000, 0, 0, 0);
        tbl[23] = v(0, 3'b111, 3'b000, 0, 0, 0);

        cyc = 0; rcnt = 0; fd_cnt = 0; first_fd = -1; last_fd = -1; last_go0 = -1;
        tick(1'b0, 1'b1, '0);
        tick(1'b0, 1'b1, '0);
        chk("reset_go", 32'(go), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_frame_done", 32'(frame_done), 0);
        chk("reset_overrun", 32'(overrun), 0);
        chk("reset_wd_err", 32'(wd_err), 0);
        chk("reset_layer_idx", 32'(layer_idx), 0);

        // Basic frame with spurious done bits on inactive layers and in idle
        restart();
        resp_en = '0;
        for (int i = 0; i < 24; i++) begin
            tick(tbl[i].s, 1'b0, tbl[i].d);
            chk($sformatf("tbl_go[%0d]", i), 32'(go), 32'(tbl[i].g));
            chk($sformatf("tbl_busy[%0d]", i), 32'(busy), 32'(tbl[i].b));
            chk($sformatf("tbl_fdone[%0d]", i), 32'(frame_done), 32'(tbl[i].f));
            if (tbl[i].idx >= 0) chk($sformatf("tbl_idx[%0d]", i), 32'(layer_idx), 32'(tbl[i].idx));
        end
        chk("tbl_overrun", 32'(overrun), 0);

        // Queued frame: second start during layer 1 runs back-to-back
        restart();
        resp_en = '1;
        busy_drop = 0;
        for (int c = 0; c < 50; c++) begin
            tick(c == 0 || c == 10, 1'b0, '0);
            if (c >= 1 && c <= 42 && !busy) busy_drop++;
        end
        chk("queue_first_fdone", 32'(first_fd), 21);
        chk("queue_last_fdone", 32'(last_fd), 42);
        chk("queue_fdone_count", 32'(fd_cnt), 2);
        chk("queue_second_go0", 32'(last_go0), 24);
        chk("queue_busy_gap", 32'(busy_drop), 0);
        chk("queue_overrun", 32'(overrun), 0);
        chk("queue_idle_busy", 32'(busy), 0);

        // Overrun: third request while one is already queued is dropped
        restart();
        resp_en = '1;
        for (int c = 0; c < 60; c++) begin
            tick(c == 0 || c == 5 || c == 8, 1'b0, '0);
            if (c == 8) chk("ovr_before", 32'(overrun), 0);
            if (c == 9) chk("ovr_after", 32'(overrun), 1);
        end
        chk("ovr_fdone_count", 32'(fd_cnt), 2);
        chk("ovr_last_fdone", 32'(last_fd), 42);
        chk("ovr_sticky", 32'(overrun), 1);

        // Reset during layer 1 WAIT aborts the frame
        restart();
        resp_en = '1;
        for (int c = 0; c < 31; c++) begin
            tick(c == 14, c == 12, '0);
            if (c == 13) begin
                chk("rst_go", 32'(go), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_idx", 32'(layer_idx), 0);
                chk("rst_fdone", 32'(frame_done), 0);
            end
        end
        chk("rst_restart_go0", 32'(last_go0), 17);
        chk("rst_fdone_count", 32'(fd_cnt), 0);

`ifdef LAYER_WATCHDOG_EN
        restart();
        resp_en = 3'b101;
        for (int c = 0; c < 41; c++) begin
            tick(c == 0, 1'b0, '0);
            if (c == 25) chk("wd_not_yet", 32'(wd_err), 0);
            if (c == 26) chk("wd_set", 32'(wd_err), 1);
            if (c == 26) chk("wd_idle", 32'(busy), 0);
        end
        chk("wd_sticky", 32'(wd_err), 1);
        chk("wd_fdone_count", 32'(fd_cnt), 0);
        restart();
        chk("wd_cleared", 32'(wd_err), 0);
`else
        chk("wd_tied_low", 32'(wd_err), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
